// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: PC/imem/hazard inputs toward the stage, next-PC and IF/ID contents back.
// master = surrounding pipeline, slave = if_fetch_stage.
interface if_fetch_stage_if #(
  parameter int DATA  = 32,
  parameter int CNT_W = 16
);
  logic [DATA-1:0]  pcIn;
  logic [DATA-1:0]  instrIn;
  logic             hazardDetected;
  logic             branchTaken;
  logic [DATA-1:0]  branchTarget;
  logic [DATA-1:0]  nextPc;
  logic             haltSignal;
  logic [DATA-1:0]  instrOut;
  logic [DATA-1:0]  pcPlus4Out;
  logic             validOut;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output pcIn, instrIn, hazardDetected, branchTaken, branchTarget,
    input  nextPc, haltSignal, instrOut, pcPlus4Out, validOut, stallCount, flushCount
  );

  modport slave (
    input  pcIn, instrIn, hazardDetected, branchTaken, branchTarget,
    output nextPc, haltSignal, instrOut, pcPlus4Out, validOut, stallCount, flushCount
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch + IF/ID register: next-PC is combinational, IF/ID updates in one cycle.
// Only back-pressure is hazardDetected (hold); branchTaken flushes and overrides it.
module if_fetch_stage #(
  parameter int          DATA        = 32,
  parameter logic [5:0]  HALT_OPCODE = 6'b010001,
  parameter int          CNT_W       = 16
) (
  input logic          clk,
  input logic          reset,
  if_fetch_stage_if.slave bus
);

  logic [DATA-1:0]  pc_plus4;
  logic [DATA-1:0]  instr_q;
  logic [DATA-1:0]  pc_plus4_q;
  logic             valid_q;
  logic             halt_q;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             halt_in_id;
  logic             halt_fetched;

  assign pc_plus4     = bus.pcIn + DATA'(4);
  assign halt_in_id   = valid_q && (instr_q[DATA-1 -: 6] == HALT_OPCODE);
  assign halt_fetched = (bus.instrIn[DATA-1 -: 6] == HALT_OPCODE);

  assign bus.nextPc     = bus.branchTaken ? bus.branchTarget : pc_plus4;
  assign bus.instrOut   = instr_q;
  assign bus.pcPlus4Out = pc_plus4_q;
  assign bus.validOut   = valid_q;
  assign bus.haltSignal = halt_q;
  assign bus.stallCount = stall_cnt;
  assign bus.flushCount = flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else if (bus.branchTaken) begin
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      // A HALT still sitting in ID was fetched down the wrong path.
      if (halt_in_id) halt_q <= 1'b0;
    end else if (bus.hazardDetected) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end else if (halt_q) begin
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= bus.instrIn;
      pc_plus4_q <= pc_plus4;
      valid_q    <= 1'b1;
      if (halt_fetched) halt_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  if_fetch_stage_if #(.DATA(32), .CNT_W(16)) bus_i ();

  if_fetch_stage #(.DATA(32), .HALT_OPCODE(6'b010001), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_i.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle off the edge before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                       input logic haz, input logic br, input logic [31:0] tgt);
    bus_i.pcIn           = pc;
    bus_i.instrIn        = instr;
    bus_i.hazardDetected = haz;
    bus_i.branchTaken    = br;
    bus_i.branchTarget   = tgt;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic vld);
    chk({tag, "_instr"}, bus_i.instrOut, instr);
    chk({tag, "_pc4"},   bus_i.pcPlus4Out, pc4);
    chk({tag, "_valid"}, 32'(bus_i.validOut), 32'(vld));
  endtask

  initial begin
    int halt_drops;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (3) step();
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    chk("rst_halt",  32'(bus_i.haltSignal), 32'h0);
    chk("rst_stall", 32'(bus_i.stallCount), 32'h0);
    chk("rst_flush", 32'(bus_i.flushCount), 32'h0);

    // Normal flow
    reset = 1'b1;
    drive(32'h0, 32'h8C220004, 1'b0, 1'b0, 32'h0);
    #1 chk("norm_nextpc", bus_i.nextPc, 32'h4);
    step();
    chk_ifid("norm", 32'h8C220004, 32'h4, 1'b1);

    // Three stall cycles with changing fetch data
    for (int i = 0; i < 3; i++) begin
      drive(32'h4, 32'h11110000 + i, 1'b1, 1'b0, 32'h0);
      step();
    end
    chk_ifid("stall", 32'h8C220004, 32'h4, 1'b1);
    chk("stall_cnt", 32'(bus_i.stallCount), 32'd3);
    chk("stall_flush", 32'(bus_i.flushCount), 32'd0);

    // Flush beats stall
    drive(32'h4, 32'h22220000, 1'b1, 1'b1, 32'h40);
    #1 chk("flush_nextpc", bus_i.nextPc, 32'h40);
    step();
    chk_ifid("flush", 32'h0, 32'h0, 1'b0);
    chk("flush_cnt", 32'(bus_i.flushCount), 32'd1);
    chk("flush_stall", 32'(bus_i.stallCount), 32'd3);

    drive(32'h40, 32'h00221820, 1'b0, 1'b0, 32'h0);
    step();
    chk_ifid("resume", 32'h00221820, 32'h44, 1'b1);

    // HALT fetch, bubble, stickiness
    drive(32'h10, 32'h44000000, 1'b0, 1'b0, 32'h0);
    step();
    chk("halt_rise", 32'(bus_i.haltSignal), 32'h1);
    chk_ifid("halt_id", 32'h44000000, 32'h14, 1'b1);
    drive(32'h10, 32'h8C220004, 1'b0, 1'b0, 32'h0);
    step();
    chk_ifid("halt_bubble", 32'h0, 32'h0, 1'b0);
    halt_drops = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_i.haltSignal !== 1'b1 || bus_i.validOut !== 1'b0) halt_drops++;
    end
    chk("halt_sticky_drops", 32'(halt_drops), 32'd0);
    drive(32'h10, 32'h8C220004, 1'b1, 1'b0, 32'h0);
    step();
    chk("halt_stall_cnt", 32'(bus_i.stallCount), 32'd4);
    drive(32'h10, 32'h8C220004, 1'b0, 1'b1, 32'h100);
    step();
    chk("halt_br_keep", 32'(bus_i.haltSignal), 32'h1);
    chk("halt_br_flush", 32'(bus_i.flushCount), 32'd2);

    // Asynchronous reset between edges
    drive(32'h10, 32'h8C220004, 1'b0, 1'b0, 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("arst_halt",  32'(bus_i.haltSignal), 32'h0);
    chk("arst_stall", 32'(bus_i.stallCount), 32'h0);
    chk("arst_flush", 32'(bus_i.flushCount), 32'h0);
    step();
    chk_ifid("arst", 32'h0, 32'h0, 1'b0);
    reset = 1'b1;

    // Wrong-path HALT
    drive(32'h20, 32'h44000000, 1'b0, 1'b0, 32'h0);
    step();
    chk("wp_halt_rise", 32'(bus_i.haltSignal), 32'h1);
    drive(32'h24, 32'h0, 1'b0, 1'b1, 32'h80);
    step();
    chk("wp_halt_clear", 32'(bus_i.haltSignal), 32'h0);
    chk("wp_flush", 32'(bus_i.flushCount), 32'd1);
    drive(32'h80, 32'h8C220004, 1'b0, 1'b0, 32'h0);
    step();
    chk_ifid("wp_resume", 32'h8C220004, 32'h84, 1'b1);

    // PC+4 wrap
    drive(32'hFFFFFFFC, 32'h00000020, 1'b0, 1'b0, 32'h0);
    #1 chk("wrap_nextpc", bus_i.nextPc, 32'h0);
    step();
    chk_ifid("wrap", 32'h00000020, 32'h0, 1'b1);

    // Stall counter saturation
    drive(32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    repeat (65534) step();
    chk("sat_fffe", 32'(bus_i.stallCount), 32'hFFFE);
    step();
    chk("sat_ffff", 32'(bus_i.stallCount), 32'hFFFF);
    step();
    chk("sat_hold", 32'(bus_i.stallCount), 32'hFFFF);
    chk_ifid("sat_ifid", 32'h00000020, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS-lite core.
- Consumes the program counter's current value and the instruction-memory read data.
- Produces the next-PC value fed back to the program counter, and the registered instruction / PC+4 / valid to decode.
- Detects the HALT opcode and drives the sticky halt signal that freezes the program counter; keeps saturating stall and flush counters for debug.

Parameters:
- DATA, 32 (from mips_pkg): address/instruction width.
- HALT_OPCODE, 6'b010001: opcode field value (instr[31:26]) that denotes HALT.
- CNT_W, 16: width of the stall and flush counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; all state is cleared while low.
- pcIn  input  DATA  current PC (program counter output).
- instrIn  input  DATA  instruction-memory data for pcIn; combinational, valid in the same cycle.
- hazardDetected  input  1  load-use stall from the hazard unit.
- branchTaken  input  1  taken branch/jump resolved in EX.
- branchTarget  input  DATA  redirect address, valid when branchTaken=1.
- nextPc  output  DATA  combinational d input of the program counter.
- haltSignal  output  1  registered, sticky; freezes the program counter.
- instrOut  output  DATA  IF/ID instruction.
- pcPlus4Out  output  DATA  IF/ID PC+4.
- validOut  output  1  IF/ID entry holds a real instruction.
- stallCount  output  CNT_W  saturating count of stall cycles.
- flushCount  output  CNT_W  saturating count of flush cycles.

Behaviour:
- Reset (reset=0, asynchronous): instrOut=0, pcPlus4Out=0, validOut=0, haltSignal=0, stallCount=0, flushCount=0. nextPc stays combinational during reset.
- pcPlus4 = pcIn + 4, modulo 2^DATA (0xFFFFFFFC wraps to 0x00000000).
- nextPc = branchTaken ? branchTarget : pcPlus4. Purely combinational, zero latency.
- haltInId (internal) = validOut && instrOut[31:26]==HALT_OPCODE.
- Per-edge register update, in priority order:
  1. Flush (branchTaken=1): instrOut<=0, pcPlus4Out<=0, validOut<=0; flushCount++ (saturating). Overrides hazardDetected and halt in the same cycle. If haltInId=1, haltSignal<=0 because the HALT is on the wrong path. Otherwise haltSignal is unchanged.
  2. Stall (hazardDetected=1, branchTaken=0): all IF/ID registers and haltSignal hold; stallCount++ (saturating). Stalls are counted even while halted.
  3. Halted (haltSignal=1, no flush, no stall): load a bubble (instrOut<=0, pcPlus4Out<=0, validOut<=0). haltSignal stays 1.
  4. Normal: instrOut<=instrIn, pcPlus4Out<=pcPlus4, validOut<=1. If instrIn[31:26]==HALT_OPCODE, haltSignal<=1 on the same edge, so haltSignal rises in the first cycle the HALT sits in ID.
- Once the HALT has left ID, haltSignal is sticky until reset; branchTaken no longer clears it but still flushes IF/ID and counts.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-operation clears everything immediately, regardless of stall, flush or halt.
- The block contains no back-pressure beyond hazardDetected. Instruction memory is assumed always ready.

Test Plan:
- Reset/normal flow: deassert reset with pcIn=0x0, instrIn=0x8C220004 -> after 1 edge instrOut=0x8C220004, pcPlus4Out=0x4, validOut=1; nextPc=0x4 combinationally.
- Stall: hazardDetected=1 for 3 cycles with instrIn changing -> IF/ID outputs hold their prior values; stallCount=3; flushCount=0.
- Flush beats stall: branchTaken=1, hazardDetected=1, branchTarget=0x40 -> nextPc=0x40 same cycle; after the edge validOut=0, instrOut=0; flushCount+1, stallCount unchanged.
- Halt: fetch instrIn=0x44000000 at pcIn=0x10 -> haltSignal=1 with instrOut=0x44000000, pcPlus4Out=0x14; the next edge loads a bubble (validOut=0); haltSignal stays 1 for 20+ cycles.
- Wrong-path halt: HALT in ID (haltSignal=1) and branchTaken=1 in that cycle -> haltSignal=0 after the edge; a later normal fetch resumes.
- Wrap/saturation/async reset: pcIn=0xFFFFFFFC -> pcPlus4Out=0x0. Force stallCount to 0xFFFF plus 1 more stall -> stays 0xFFFF. Pull reset low between edges -> all outputs go to 0 without waiting for clk.
